// File: rtl/debug_tx_sequencer.sv
// Streams a post-run state dump (PC, cycle count, register file, data memory) to UART_tx,
// four bytes per word, MSB first, driving the register-file and memory read ports itself.
module debug_tx_sequencer #(
  parameter int SIZE_TRAMA    = 8,
  parameter int BITS_SIZE     = 32,
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 16,
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_ADDR_BITS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [BITS_SIZE-1:0]     i_pc,
  input  logic [BITS_SIZE-1:0]     i_clk_count,
  output logic [REG_ADDR_BITS-1:0] o_reg_addr,
  input  logic [BITS_SIZE-1:0]     i_reg_data,
  output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
  input  logic [BITS_SIZE-1:0]     i_mem_data,
  output logic                     o_tx_start,
  output logic [SIZE_TRAMA-1:0]    o_tx_data,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int LAST      = NUM_REGS + NUM_MEM_WORDS + 1;
  localparam int WIDX_BITS = $clog2(LAST + 1);

  localparam logic [WIDX_BITS-1:0] WIDX_ONE  = WIDX_BITS'(1);
  localparam logic [WIDX_BITS-1:0] WIDX_TWO  = WIDX_BITS'(2);
  localparam logic [WIDX_BITS-1:0] WIDX_NREG = WIDX_BITS'(NUM_REGS);
  localparam logic [WIDX_BITS-1:0] REG_END   = WIDX_BITS'(NUM_REGS + 1);
  localparam logic [WIDX_BITS-1:0] WIDX_LAST = WIDX_BITS'(LAST);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT, NEXT, ADDR, DONE
  } state_t;

  state_t state, state_next;

  logic [BITS_SIZE-1:0]     pc_q, cnt_q, shift;
  logic [WIDX_BITS-1:0]     widx, widx_inc;
  logic [1:0]               bidx;
  logic [REG_ADDR_BITS-1:0] reg_addr_q;
  logic [MEM_ADDR_BITS-1:0] mem_addr_q;
  logic                     last_word, word_is_reg, next_is_reg, next_is_mem;

  assign widx_inc    = widx + WIDX_ONE;
  assign last_word   = (widx == WIDX_LAST);
  assign word_is_reg = (widx <= REG_END);
  assign next_is_reg = (widx_inc >= WIDX_TWO) && (widx_inc <= REG_END);
  assign next_is_mem = (widx_inc > REG_END);

  assign o_tx_data  = shift[BITS_SIZE-1 -: SIZE_TRAMA];
  assign o_reg_addr = reg_addr_q;
  assign o_mem_addr = mem_addr_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    o_busy     = 1'b1;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = LOAD;
      end
      LOAD: state_next = SEND;
      SEND: begin
        o_tx_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (i_tx_done) state_next = (bidx == 2'd3) ? NEXT : SEND;
      end
      NEXT: state_next = last_word ? DONE : ADDR;
      ADDR: state_next = LOAD;
      DONE: begin
        o_done     = 1'b1;
        o_busy     = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word source is selected by widx; read addresses are issued one state ahead of LOAD
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q       <= '0;
      cnt_q      <= '0;
      shift      <= '0;
      widx       <= '0;
      bidx       <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            pc_q  <= i_pc;
            cnt_q <= i_clk_count;
            widx  <= '0;
          end
        end
        LOAD: begin
          if (widx == '0)       shift <= pc_q;
          else if (widx == WIDX_ONE) shift <= cnt_q;
          else if (word_is_reg) shift <= i_reg_data;
          else                  shift <= i_mem_data;
          bidx <= '0;
        end
        WAIT: begin
          if (i_tx_done && bidx != 2'd3) begin
            shift <= shift << SIZE_TRAMA;
            bidx  <= bidx + 2'd1;
          end
        end
        NEXT: begin
          if (!last_word) begin
            widx <= widx_inc;
            if (next_is_reg) reg_addr_q <= REG_ADDR_BITS'(widx_inc - WIDX_TWO);
            if (next_is_mem) mem_addr_q <= MEM_ADDR_BITS'(widx_inc - WIDX_TWO - WIDX_NREG);
          end
        end
        DONE: begin
          reg_addr_q <= '0;
          mem_addr_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
